// File: rtl/majority_sequencer_if.sv
// ----------------------------------------------------------------------------
// majority_sequencer_if
//
// Groups every non-clock signal of the majority sequencer into one bundle.
// The slave modport is the sequencer's view. The master modport is the view of
// the surrounding environment: host run control, the core result source and
// the majority counter.
//
// Handshake rule: a result vector moves on a rising clock edge where
// item_valid and item_ready are both high. item_valid may rise and fall
// freely, and the sequencer never depends on it being held. item_ready is a
// pure function of sequencer state.
//
// Signals:
//   start, abort            host run control (pulse / synchronous)
//   cfg_items/cores/even/rand_bit   pass configuration, latched on start
//   item_valid, item_ready  result-vector handshake
//   cnt_clear, cnt_tmp_even, cnt_tmp_rand_bit, cnt_update, cnt_core_enable
//                           drive the majority counter
//   cnt_sign_bit            counter's sign output
//   busy, done, sign_out    run status and captured result
// ----------------------------------------------------------------------------
interface majority_sequencer_if #(
    parameter int N_W = 20
);
    logic           start;
    logic           abort;
    logic [N_W-1:0] cfg_items;
    logic [5:0]     cfg_cores;
    logic           cfg_even;
    logic           cfg_rand_bit;
    logic           item_valid;
    logic           item_ready;
    logic           cnt_clear;
    logic           cnt_tmp_even;
    logic           cnt_tmp_rand_bit;
    logic           cnt_update;
    logic [31:0]    cnt_core_enable;
    logic           cnt_sign_bit;
    logic           busy;
    logic           done;
    logic           sign_out;

    modport slave (
        input  start, abort, cfg_items, cfg_cores, cfg_even, cfg_rand_bit,
        input  item_valid, cnt_sign_bit,
        output item_ready, cnt_clear, cnt_tmp_even, cnt_tmp_rand_bit,
        output cnt_update, cnt_core_enable, busy, done, sign_out
    );

    modport master (
        output start, abort, cfg_items, cfg_cores, cfg_even, cfg_rand_bit,
        output item_valid, cnt_sign_bit,
        input  item_ready, cnt_clear, cnt_tmp_even, cnt_tmp_rand_bit,
        input  cnt_update, cnt_core_enable, busy, done, sign_out
    );
endinterface

// File: rtl/majority_sequencer.sv
// ----------------------------------------------------------------------------
// majority_sequencer
//
// Runs one bundling pass of the 32-core majority counter. It performs these
// steps in order:
//   1. Clears the counter and presents the tie-break seed.
//   2. Sets the core-enable mask.
//   3. Meters accepted result vectors into update pulses spaced UPD_GAP
//      cycles apart.
//   4. Waits out the counter's adder tree.
//   5. Captures the final sign and pulses done.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          majority_sequencer_if.slave (run control, cfg, item
//                handshake, counter drive, status)
//   o_dbg_state  current FSM state encoding, for observation only
//
// Parameters:
//   N_W          item count width
//   UPD_GAP      minimum spacing of cnt_update pulses (>= 3)
//   DRAIN_CYC    cycles from the last cnt_update until cnt_sign_bit is final
// ----------------------------------------------------------------------------
module majority_sequencer #(
    parameter int N_W       = 20,
    parameter int UPD_GAP   = 3,
    parameter int DRAIN_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    majority_sequencer_if.slave      bus,
    output logic [2:0]               o_dbg_state
);

    localparam int GAP_W   = (UPD_GAP > 2)   ? $clog2(UPD_GAP)   : 1;
    localparam int DRAIN_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

    // GAP lasts UPD_GAP-1 cycles, so the down-counter starts at UPD_GAP-2.
    localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(UPD_GAP - 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCEPT = 3'd2,
        S_GAP    = 3'd3,
        S_DRAIN  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [N_W-1:0]       r_remaining;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_update;
    logic [31:0]          r_core_enable;
    logic                 r_even;
    logic                 r_rand_bit;
    logic                 r_sign;

    logic                 w_handshake;
    logic                 w_abort;
    logic                 w_capture;
    logic [5:0]           w_cores_sat;
    logic [31:0]          w_mask;

    logic                 w_item_ready;
    logic                 w_cnt_clear;
    logic                 w_busy;
    logic                 w_done;

    // ACCEPT is the only state that raises item_ready, so a transfer is
    // simply item_valid seen in ACCEPT.
    assign w_handshake = (r_state == S_ACCEPT) && bus.item_valid;
    assign w_abort     = bus.abort && (r_state != S_IDLE);
    assign w_capture   = (r_state == S_DRAIN) && (r_drain_cnt == '0);

    // Thermometer mask. Bit 5 set after saturation means exactly 32 cores,
    // which is the all-ones mask. Otherwise the shift amount stays below 32.
    assign w_cores_sat = (bus.cfg_cores > 6'd32) ? 6'd32 : bus.cfg_cores;
    assign w_mask      = w_cores_sat[5] ? 32'hFFFF_FFFF
                                        : ((32'd1 << w_cores_sat[4:0]) - 32'd1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_next_state = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    w_next_state = (r_remaining != '0) ? S_ACCEPT : S_DRAIN;
                end
                S_ACCEPT: begin
                    if (bus.item_valid) begin
                        w_next_state = S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        w_next_state = (r_remaining != '0) ? S_ACCEPT : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        w_next_state = S_FINISH;
                    end
                end
                S_FINISH: begin
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_item_ready = 1'b0;
        w_cnt_clear  = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        unique case (r_state)
            S_IDLE:   w_busy       = 1'b0;
            S_CLEAR:  w_cnt_clear  = 1'b1;
            S_ACCEPT: w_item_ready = 1'b1;
            S_FINISH: w_done       = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: configuration latch, counters, update pulse, sign capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining   <= '0;
            r_gap_cnt     <= '0;
            r_drain_cnt   <= '0;
            r_update      <= 1'b0;
            r_core_enable <= '0;
            r_even        <= 1'b0;
            r_rand_bit    <= 1'b0;
            r_sign        <= 1'b0;
        end else begin
            // An abort in the handshake cycle kills the pending update.
            r_update <= w_handshake && !bus.abort;

            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_remaining   <= bus.cfg_items;
                    r_even        <= bus.cfg_even;
                    r_rand_bit    <= bus.cfg_rand_bit;
                    r_core_enable <= w_mask;
                end
            end else if (bus.abort) begin
                r_core_enable <= '0;
                r_remaining   <= '0;
                r_gap_cnt     <= '0;
                r_drain_cnt   <= '0;
            end else begin
                if (w_handshake && (r_remaining != '0)) begin
                    r_remaining <= r_remaining - N_W'(1);
                end

                if (w_handshake) begin
                    r_gap_cnt <= GAP_LOAD;
                end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                end

                // The drain window is timed from the last update pulse, not
                // from entry into DRAIN. The counter reloads on every pulse,
                // and on CLEAR for an empty pass, and then runs through GAP.
                // Because of this the window stays exact as long as
                // UPD_GAP-1 <= DRAIN_CYC.
                if ((r_state == S_CLEAR) || r_update) begin
                    r_drain_cnt <= DRAIN_LOAD;
                end else if (r_drain_cnt != '0) begin
                    r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                end

                if (w_capture) begin
                    r_sign <= bus.cnt_sign_bit;
                end
            end
        end
    end

    assign bus.item_ready       = w_item_ready;
    assign bus.cnt_clear        = w_cnt_clear;
    assign bus.busy             = w_busy;
    assign bus.done             = w_done;
    assign bus.cnt_update       = r_update;
    assign bus.cnt_core_enable  = r_core_enable;
    assign bus.cnt_tmp_even     = r_even;
    assign bus.cnt_tmp_rand_bit = r_rand_bit;
    assign bus.sign_out         = r_sign;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_majority_sequencer.sv
module tb_majority_sequencer;

  localparam int N_W = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  majority_sequencer_if #(.N_W(N_W)) bus ();
  logic [2:0] dbg_state;

  majority_sequencer #(.N_W(N_W), .UPD_GAP(3), .DRAIN_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive point: 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- counter stand-in ----------------
  // Behavioural majority counter: signed running sum of +/-1 votes over the
  // enabled cores plus the seed, with the sign visible 4 cycles after the
  // update cycle.
  logic [31:0] item_vec = '0;
  logic [31:0] pend_q[$];
  int          acc_cnt = 0;
  int          stub_sum = 0;
  logic [3:0]  sign_d = '0;

  assign bus.cnt_sign_bit = sign_d[3];

  always @(posedge clk) begin
    logic [31:0] v;
    if (bus.cnt_clear) begin
      stub_sum = bus.cnt_tmp_even ? (bus.cnt_tmp_rand_bit ? -1 : 1) : 0;
      pend_q.delete();
    end
    if (bus.item_valid && bus.item_ready) begin
      pend_q.push_back(item_vec);
      acc_cnt++;
    end
    if (bus.cnt_update && pend_q.size() > 0) begin
      v = pend_q.pop_front();
      for (int c = 0; c < 32; c++)
        if (bus.cnt_core_enable[c]) stub_sum += v[c] ? 1 : -1;
    end
    sign_d <= {sign_d[2:0], (stub_sum < 0)};
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_upd, n_done, last_upd, done_cyc, clear_cyc, min_gap, max_gap, overlap;
  logic clr_even, clr_rand;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cnt_update) begin
        if (last_upd >= 0) begin
          if (cyc - last_upd < min_gap) min_gap = cyc - last_upd;
          if (cyc - last_upd > max_gap) max_gap = cyc - last_upd;
        end
        n_upd++;
        last_upd = cyc;
      end
      if (bus.cnt_clear) begin
        clear_cyc = cyc;
        clr_even  = bus.cnt_tmp_even;
        clr_rand  = bus.cnt_tmp_rand_bit;
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.cnt_update && bus.cnt_clear) overlap++;
    end
  end

  task automatic mon_reset();
    n_upd = 0; n_done = 0; last_upd = -1; done_cyc = -1; clear_cyc = -1;
    min_gap = 1000; max_gap = 0; overlap = 0;
  endtask

  // ---------------- vector table ----------------
  // mode: 0 random vectors, 1 all ones, 2 item0=0x0 / others=0xF
  // exp_sign: 0/1 fixed expectation, 2 = take it from the reference model
  typedef struct {
    int          items;
    int          cores;
    bit          even;
    bit          rnd;
    int          prob;
    int          mode;
    bit          poke_start;
    logic [31:0] exp_mask;
    int          exp_sign;
  } row_t;

  row_t rows[7];

  // One complete pass: drive cfg, feed items, check against the model.
  task automatic run_pass(input row_t r, input string tag);
    logic [31:0] vecs[$];
    int base, k, nc, s, exp_sign;
    vecs.delete();
    for (int i = 0; i < r.items; i++) begin
      if (r.mode == 1)      vecs.push_back(32'hFFFF_FFFF);
      else if (r.mode == 2) vecs.push_back(i == 0 ? 32'h0 : 32'hF);
      else                  vecs.push_back($urandom);
    end
    // Reference: sign of seed + sum of +/-1 votes over the active cores.
    nc = (r.cores > 32) ? 32 : r.cores;
    s  = r.even ? (r.rnd ? -1 : 1) : 0;
    foreach (vecs[i])
      for (int c = 0; c < nc; c++) s += vecs[i][c] ? 1 : -1;
    exp_sign = (r.exp_sign == 2) ? ((s < 0) ? 1 : 0) : r.exp_sign;

    mon_reset();
    bus.cfg_items    = N_W'(r.items);
    bus.cfg_cores    = 6'(r.cores);
    bus.cfg_even     = r.even;
    bus.cfg_rand_bit = r.rnd;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 4000 && n_done == 0; i++) begin
      k = acc_cnt - base;
      if (k < r.items) begin
        bus.item_valid = ($urandom_range(0, 99) < r.prob);
        item_vec       = vecs[k];
      end else begin
        bus.item_valid = 1'b0;
      end
      if (r.poke_start && i == 20) begin
        bus.start     = 1'b1;
        bus.cfg_cores = 6'd1;
        bus.cfg_items = N_W'(5);
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.item_valid = 1'b0;
    bus.start      = 1'b0;
    chk({tag, " done_seen"}, (n_done > 0) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, " busy_after"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " done_width"}, {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk({tag, " upd_count"}, n_upd, r.items);
    chk({tag, " done_count"}, n_done, 32'd1);
    if (r.items > 0)
      chk({tag, " done_lat"}, done_cyc - last_upd, 32'd5);
    else
      chk({tag, " done_lat0"}, done_cyc - clear_cyc, 32'd5);
    chk({tag, " mask"}, bus.cnt_core_enable, r.exp_mask);
    chk({tag, " sign"}, {31'd0, bus.sign_out}, exp_sign);
    chk({tag, " seed"}, {30'd0, clr_even, clr_rand}, {30'd0, r.even, r.rnd});
    chk({tag, " overlap"}, overlap, 32'd0);
    if (r.items > 1) begin
      chk({tag, " min_gap"}, (min_gap >= 3) ? 32'd1 : 32'd0, 32'd1);
      if (r.prob == 100) chk({tag, " max_gap"}, max_gap, 32'd3);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bit seen;
    rows[0] = '{1,   32, 1'b0, 1'b0, 100, 1, 1'b0, 32'hFFFF_FFFF, 0};
    rows[1] = '{2,    4, 1'b1, 1'b1, 100, 2, 1'b0, 32'h0000_000F, 1};
    rows[2] = '{0,    7, 1'b1, 1'b0, 100, 0, 1'b0, 32'h0000_007F, 0};
    rows[3] = '{100, 17, 1'b0, 1'b0,  50, 0, 1'b1, 32'h0001_FFFF, 2};
    rows[4] = '{9,    0, 1'b1, 1'b1,  70, 0, 1'b0, 32'h0000_0000, 2};
    rows[5] = '{6,   31, 1'b1, 1'b0,  80, 0, 1'b0, 32'h7FFF_FFFF, 2};
    rows[6] = '{3,   40, 1'b0, 1'b0, 100, 1, 1'b0, 32'hFFFF_FFFF, 0};

    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_items = '0; bus.cfg_cores = '0;
    bus.cfg_even = 1'b0; bus.cfg_rand_bit = 1'b0; bus.item_valid = 1'b0;
    mon_reset();

    // Reset state
    tick(); tick();
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst mask", bus.cnt_core_enable, 32'd0);
    chk("rst sign", {31'd0, bus.sign_out}, 32'd0);
    chk("rst ready", {31'd0, bus.item_ready}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_pass(rows[i], $sformatf("row%0d", i));

    // Abort in the same cycle as a handshake, after a pass leaving sign_out=1.
    run_pass(rows[1], "pre_abort");
    mon_reset();
    bus.cfg_items = N_W'(5); bus.cfg_cores = 6'd8; bus.cfg_even = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    base = acc_cnt;
    bus.item_valid = 1'b1;
    item_vec = 32'hFF;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.item_ready && (acc_cnt - base) >= 2) seen = 1'b1;
      else tick();
    end
    chk("abort reach", {31'd0, seen}, 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.item_valid = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort ready", {31'd0, bus.item_ready}, 32'd0);
    chk("abort upd", {31'd0, bus.cnt_update}, 32'd0);
    chk("abort mask", bus.cnt_core_enable, 32'd0);
    n_upd = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort no_upd", n_upd, 32'd0);
    chk("abort no_done", n_done, 32'd0);
    chk("abort sign", {31'd0, bus.sign_out}, 32'd1);

    // Asynchronous reset mid-GAP, then a saturating-core pass.
    bus.cfg_items = N_W'(3); bus.cfg_cores = 6'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.item_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.cnt_update) seen = 1'b1;
      else tick();
    end
    chk("gap reach", {31'd0, seen}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst mask", bus.cnt_core_enable, 32'd0);
    chk("arst sign", {31'd0, bus.sign_out}, 32'd0);
    chk("arst busy", {31'd0, bus.busy}, 32'd0);
    chk("arst done", {31'd0, bus.done}, 32'd0);
    chk("arst upd", {31'd0, bus.cnt_update}, 32'd0);
    chk("arst ready", {31'd0, bus.item_ready}, 32'd0);
    chk("arst seed", {30'd0, bus.cnt_tmp_even, bus.cnt_tmp_rand_bit}, 32'd0);
    bus.item_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_pass(rows[6], "sat40");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/majority_sequencer.md
# majority_sequencer

Controller that sequences one bundling pass of the 32-core majority counter. It loads the counter's tie-break seed, configures the per-core enable mask, and meters core results into the counter as correctly spaced `update` pulses. It waits out the counter's 3-stage adder tree, then returns the final sign bit with a one-cycle `done` pulse. It sits between the host-side run control and the counter instance.

## Interface
Parameters:
- `N_W`, 20: width of the item count per pass.
- `UPD_GAP`, 3: minimum cycles between consecutive `cnt_update` pulses. Must be ≥3, because the counter's update stages are priority-exclusive.
- `DRAIN_CYC`, 4: cycles from the last `cnt_update` until `cnt_sign_bit` is final.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: pulse; begins a pass when in IDLE.
- `abort` in 1: synchronous; ends the current pass without `done`.
- `cfg_items` in N_W: number of result vectors to accumulate (0 allowed).
- `cfg_cores` in 6: number of active cores, 0..32. Values >32 saturate to 32.
- `cfg_even` in 1: item count is even, so a tie-break seed is needed.
- `cfg_rand_bit` in 1: seed polarity (0 → +1, 1 → −1).
- `item_valid` in 1: the cores present a result vector.
- `item_ready` out 1: the sequencer accepts a vector this cycle.
- `cnt_clear` out 1: drives the counter's synchronous `rst`.
- `cnt_tmp_even`, `cnt_tmp_rand_bit` out 1 each: drive the counter's seed inputs.
- `cnt_update` out 1: drives the counter's `update`.
- `cnt_core_enable` out 32: drives the counter's `core_enable`.
- `cnt_sign_bit` in 1: the counter's `sign_bit`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the pass completes.
- `sign_out` out 1: captured majority sign; holds until the next capture.

## Operation
- States: IDLE, CLEAR, ACCEPT, GAP, DRAIN, FINISH.

**IDLE**
- When `start`=1, latch all cfg_* inputs.
- Set `cnt_core_enable` to the thermometer mask `(1<<cores)−1`; for cores=32 the mask is all ones.
- Next state: CLEAR.
- `start` outside IDLE is ignored.

**CLEAR**
- One cycle.
- `cnt_clear`=1. `cnt_tmp_even` and `cnt_tmp_rand_bit` are driven from the latched values.
- Next state: ACCEPT if items>0, else DRAIN.
- The seed outputs are held at the latched values for the whole pass.

**ACCEPT**
- `item_ready`=1.
- On handshake (`item_valid`&`item_ready`):
  - decrement the remaining count;
  - register `cnt_update`=1 for exactly the next cycle;
  - go to GAP.

**GAP**
- `item_ready`=0. Stays for UPD_GAP−1 cycles.
- Then go to ACCEPT if remaining>0, else DRAIN.

**DRAIN**
- Counts DRAIN_CYC cycles, starting the cycle after the last `cnt_update`, or after CLEAR when items=0.
- In the last DRAIN cycle, register `cnt_sign_bit` into `sign_out`.
- Next state: FINISH.

**FINISH**
- `done`=1 for one cycle, then IDLE.

**Arithmetic**
- The remaining counter is N_W bits and never wraps: it decrements only when nonzero.
- Gap and drain counters are ⌈log2⌉-wide down-counters.

**abort** (any non-IDLE state)
- Next state IDLE. `cnt_update` and `item_ready` deassert immediately from the next cycle.
- No `done`; `sign_out` is unchanged.
- `cnt_core_enable` goes to 0.
- A pending `cnt_update` registered in the same cycle as the abort is suppressed.

**Reset** (`rst_n`=0, at any time)
- All outputs are 0: `cnt_core_enable`=0, `sign_out`=0, `busy`=0, `done`=0.
- State IDLE; counters cleared.

## Timing
- `start` in cycle s → CLEAR in cycle s+1, `busy`=1 from s+1.
- Handshake in cycle t → `cnt_update` in t+1. Next possible handshake is t+UPD_GAP, so `cnt_update` pulses are ≥UPD_GAP apart.
- Last `cnt_update` in cycle u:
  - `sign_out` is valid from cycle u+DRAIN_CYC+1;
  - `done` is high in u+DRAIN_CYC+1;
  - `busy` is low from u+DRAIN_CYC+2.
- items=0 with CLEAR in cycle c: `done` is high in c+DRAIN_CYC+1.
- `item_valid` held high continuously yields one item per UPD_GAP cycles.
- `item_valid` low in ACCEPT simply stalls; there is no timeout.
- `cnt_update` and `cnt_clear` are never high in the same cycle.

## Test plan
- **Basic pass.** Reset; cfg_items=1, cores=32, even=0; `item_valid` held high; counter result all ones.
  - → exactly one `cnt_update`; `cnt_core_enable`=0xFFFFFFFF; `done` 5 cycles after `cnt_update`; `sign_out`=0.
- **Even with seed.** cfg_items=2, even=1, rand=1, cores=4. Results: item 0 = 0x0 (all −1), item 1 = 0xF (all +1).
  - → two `cnt_update` pulses exactly 3 cycles apart; total is −1, so `sign_out`=1.
- **Zero items.** cfg_items=0, even=1, rand=0.
  - → no `cnt_update`; `done` 5 cycles after CLEAR; `sign_out`=0.
- **Stalls and ignored start.** `item_valid` toggled randomly over 100 items, with `start` pulsed while busy.
  - → exactly 100 `cnt_update` pulses, each ≥3 apart; the second `start` has no effect; `done` fires once.
- **Abort.** `abort` asserted in the same cycle as a handshake mid-pass.
  - → no `cnt_update` follows; IDLE next cycle; no `done`; `sign_out` keeps its prior value.
- **Reset and saturation.** `rst_n` pulsed low asynchronously mid-GAP; cfg_cores=40 on the next pass.
  - → all outputs 0 immediately after the reset; the next pass produces mask 0xFFFFFFFF.
